// File: rtl/fpu_pkg.sv
// Shared FPU number format and arbiter FSM encoding.
// Format: {sign, exp[EXP_W-1:0] biased by BIAS, mant[MANT_W-1:0]}.
package fpu_pkg;

    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;
    localparam int BIAS   = 31;
    localparam int FP_W   = 1 + EXP_W + MANT_W;
    localparam int STAT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } fpu_arb_state_t;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester/response bundle of fpu_arbiter. Handshake: a request moves when
// reqN_valid and reqN_ready are both high on a rising edge; a result moves when
// rsp_valid and rsp_ready are both high on a rising edge. valid never waits on ready.
interface fpu_arbiter_if;
    import fpu_pkg::*;

    logic              req0_valid;
    logic [FP_W-1:0]   req0_a;
    logic [FP_W-1:0]   req0_b;
    logic              req0_ready;
    logic              req1_valid;
    logic [FP_W-1:0]   req1_a;
    logic [FP_W-1:0]   req1_b;
    logic              req1_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [FP_W-1:0]   rsp_data;
    logic [STAT_W-1:0] rsp_status;

    // master: the requesters and the result consumer
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_status
    );

    // slave: the arbiter
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_status
    );

endinterface

// File: rtl/fpu_arb_grant.sv
// Two-way grant: a lone requester always wins; on a tie the requester that
// was not granted last (ptr_i holds the last winner's index) wins.
module fpu_arb_grant (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    assign grant_o[0] = valid_i[0] & (~valid_i[1] | ptr_i);
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~ptr_i);

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one multi-cycle FPU between two requesters: grant, restart FPU, wait, hold result.
// Define FPU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int FPU_LATENCY = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [FP_W-1:0]   req0_a,
    input  logic [FP_W-1:0]   req0_b,
    input  logic              req1_valid,
    input  logic [FP_W-1:0]   req1_a,
    input  logic [FP_W-1:0]   req1_b,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [FP_W-1:0]   rsp_data,
    output logic [STAT_W-1:0] rsp_status,
    output logic              fpu_reset,
    output logic [FP_W-1:0]   fpu_op_a,
    output logic [FP_W-1:0]   fpu_op_b,
    input  logic [FP_W-1:0]   fpu_data_in,
    input  logic [STAT_W-1:0] fpu_status_in
);

    localparam logic [3:0] LAT4 = 4'(FPU_LATENCY);

    fpu_arb_state_t    state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              id_q, id_d;
    logic [FP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [FP_W-1:0]   data_q, data_d;
    logic [STAT_W-1:0] status_q, status_d;
    logic [1:0]        grant;
    logic [1:0]        ready_c;
    logic              ptr;

    fpu_arb_grant u_grant (
        .valid_i ({req1_valid, req0_valid}),
        .ptr_i   (ptr),
        .grant_o (grant)
    );

`ifdef FPU_ARB_RR_EN
    logic ptr_q, ptr_d;

    assign ptr   = ptr_q;
    assign ptr_d = (state_q == IDLE && |grant) ? grant[1] : ptr_q;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr_q <= 1'b1;
        else        ptr_q <= ptr_d;
    end
`else
    assign ptr = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        data_d    = data_q;
        status_d  = status_q;
        ready_c   = 2'b00;
        rsp_valid = 1'b0;
        fpu_reset = 1'b1;
        unique case (state_q)
            IDLE: begin
                ready_c = grant;
                if (|grant) begin
                    id_d    = grant[1];
                    op_a_d  = grant[1] ? req1_a : req0_a;
                    op_b_d  = grant[1] ? req1_b : req0_b;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                fpu_reset = 1'b0;
                cnt_d     = LAT4;
                state_d   = WAIT;
            end
            WAIT: begin
                // The FPU output is valid in the final WAIT cycle only.
                if (cnt_q == 4'd1) begin
                    data_d   = fpu_data_in;
                    status_d = fpu_status_in;
                    cnt_d    = 4'd0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are masked while reset is held so no request is acknowledged then.
    assign req0_ready = ready_c[0] & reset;
    assign req1_ready = ready_c[1] & reset;
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_status = status_q;
    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: vector table plus reset/backpressure sequences, behavioural FPU,
// and a result queue checked whenever a response is presented.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int LAT = 6;

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] r0;
    logic [31:0] r1;
    int          bp;
    logic        ghost;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fpu_reset;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data_in;
  logic [3:0]  fpu_status_in;

  fpu_arbiter_if bus ();

  always #5 clock = ~clock;

  fpu_arbiter #(.FPU_LATENCY(LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (bus.req0_valid),
    .req0_a        (bus.req0_a),
    .req0_b        (bus.req0_b),
    .req1_valid    (bus.req1_valid),
    .req1_a        (bus.req1_a),
    .req1_b        (bus.req1_b),
    .req0_ready    (bus.req0_ready),
    .req1_ready    (bus.req1_ready),
    .rsp_valid     (bus.rsp_valid),
    .rsp_ready     (bus.rsp_ready),
    .rsp_id        (bus.rsp_id),
    .rsp_data      (bus.rsp_data),
    .rsp_status    (bus.rsp_status),
    .fpu_reset     (fpu_reset),
    .fpu_op_a      (fpu_op_a),
    .fpu_op_b      (fpu_op_b),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int launches = 0;
  int grant_cyc = 0;
  int rsp_seen = 0;
  bit in_resp = 1'b0;
  bit rr_ptr = 1'b1;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Reference adder for the {sign, exp6, mant25} format (no rounding, no overflow).
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    logic [5:0]  ex, ey;
    logic [26:0] mx, my, s;
    int          sh;
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    x = a;
    y = b;
    if (y[30:0] > x[30:0]) begin
      t = x; x = y; y = t;
    end
    ex = x[30:25];
    ey = y[30:25];
    mx = {2'b01, x[24:0]};
    my = {2'b01, y[24:0]};
    sh = int'(ex) - int'(ey);
    my = (sh > 26) ? 27'd0 : (my >> sh);
    if (x[31] == y[31]) begin
      s = mx + my;
      if (s[26]) begin
        s  = s >> 1;
        ex = ex + 6'd1;
      end
    end else begin
      s = mx - my;
      if (s == 27'd0) return 32'd0;
      while (!s[25]) begin
        s  = s << 1;
        ex = ex - 6'd1;
      end
    end
    return {x[31], ex, s[24:0]};
  endfunction

  function automatic logic [3:0] status_of(input logic [31:0] r);
    return {r[30:0] == 31'd0, r[31], 2'b01};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = {1'($urandom_range(0, 1)), 6'($urandom_range(24, 38)), 25'($urandom)};
    return r;
  endfunction

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input int bp, input logic ghost);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.r0 = r0; v.r1 = r1;
    v.bp = bp; v.ghost = ghost;
    return v;
  endfunction

  // Behavioural FPU: result appears LAT cycles after the restart pulse, garbage before.
  int          st_cnt;
  logic [31:0] st_res;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_cnt <= 0;
      st_res <= 32'd0;
    end else if (!fpu_reset) begin
      st_cnt <= 1;
      st_res <= fp_add(fpu_op_a, fpu_op_b);
    end else if (st_cnt != 0 && st_cnt < LAT) begin
      st_cnt <= st_cnt + 1;
    end
  end
  assign fpu_data_in   = (st_cnt == LAT) ? st_res : 32'hDEAD_BEEF;
  assign fpu_status_in = (st_cnt == LAT) ? status_of(st_res) : 4'hE;

  // Response monitor and scoreboard.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      in_resp = 1'b0;
    end else begin
      if (!fpu_reset) launches++;
      if (bus.req0_ready || bus.req1_ready) grant_cyc = cyc;
      if (bus.rsp_valid) begin
        rsp_seen++;
        if (!in_resp) begin
          chk("latency", 37'(cyc - grant_cyc), 37'(LAT + 2));
          in_resp = 1'b1;
        end
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          chk("rsp", {bus.rsp_id, bus.rsp_status, bus.rsp_data}, exp_q[0]);
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
        if (bus.rsp_ready) in_resp = 1'b0;
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_rsp_valid", 37'(bus.rsp_valid), 37'(0));
    chk("rst_rsp_id", 37'(bus.rsp_id), 37'(0));
    chk("rst_rsp_data", 37'(bus.rsp_data), 37'(0));
    chk("rst_rsp_status", 37'(bus.rsp_status), 37'(0));
    chk("rst_op_a", 37'(fpu_op_a), 37'(0));
    chk("rst_op_b", 37'(fpu_op_b), 37'(0));
    chk("rst_fpu_reset", 37'(fpu_reset), 37'(1));
    chk("rst_ready", 37'({bus.req1_ready, bus.req0_ready}), 37'(0));
  endtask

  task automatic set_valid(input logic idx, input logic val);
    if (idx) bus.req1_valid = val;
    else     bus.req0_valid = val;
  endtask

  task automatic run_vec(input vec_t v);
    logic        id;
    logic [31:0] ea, eb, er;
    bit          got;
    int          l0;
    l0 = launches;
    bus.rsp_ready  = (v.bp == 0);
    bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0;
    bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (bus.req0_ready || bus.req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fail_now("grant_timeout");
      return;
    end
    if (v.v0 && v.v1) begin
`ifdef FPU_ARB_RR_EN
      id = ~rr_ptr;
`else
      id = 1'b0;
`endif
    end else begin
      id = ~v.v0;
    end
    chk("grant", 37'({bus.req1_ready, bus.req0_ready}), id ? 37'(2) : 37'(1));
    rr_ptr = id;
    ea = id ? v.a1 : v.a0;
    eb = id ? v.b1 : v.b0;
    er = id ? v.r1 : v.r0;
    exp_q.push_back({id, status_of(er), er});
    @(posedge clock); #1;
    set_valid(id, 1'b0);
    if (id) begin bus.req1_a = $urandom; bus.req1_b = $urandom; end
    else    begin bus.req0_a = $urandom; bus.req0_b = $urandom; end
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      chk("op_a", 37'(fpu_op_a), 37'(ea));
      chk("op_b", 37'(fpu_op_b), 37'(eb));
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      chk("busy_ready", 37'({bus.req1_ready, bus.req0_ready}), 37'(0));
      @(posedge clock); #1;
      if (v.ghost) set_valid(~id, (t == 1 || t == 2));
    end
    if (!got) begin
      fail_now("rsp_timeout");
      return;
    end
    if (v.bp > 0) begin
      for (int t = 0; t < v.bp; t++) begin
        @(posedge clock); #1;
        set_valid(~id, 1'b1);
        @(negedge clock);
        chk("bp_valid", 37'(bus.rsp_valid), 37'(1));
        chk("bp_ready", 37'({bus.req1_ready, bus.req0_ready}), 37'(0));
        chk("bp_fpu_reset", 37'(fpu_reset), 37'(1));
      end
      @(posedge clock); #1;
      bus.rsp_ready = 1'b1;
      set_valid(~id, 1'b0);
    end
    @(posedge clock); #1;
    chk("launch_count", 37'(launches - l0), 37'(1));
    chk("queue_empty", 37'(exp_q.size()), 37'(0));
  endtask

  vec_t tbl[11];
  vec_t rv;
  int   seen0;
  bit   got;

  initial begin
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3E00_0000; bus.req0_b = 32'h3E00_0000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h0; bus.req1_b = 32'h0;
    bus.rsp_ready  = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;

    tbl[0]  = mk(1, 32'h3E00_0000, 32'h3E00_0000, 0, 32'h0, 32'h0, 32'h4000_0000, 32'h0, 0, 0);
    tbl[1]  = mk(1, 32'h4000_0000, 32'h4000_0000, 1, 32'h3E00_0000, 32'hBE00_0000,
                 32'h4200_0000, 32'h0, 0, 0);
    tbl[2]  = mk(0, 32'h0, 32'h0, 1, 32'h3E00_0000, 32'hBE00_0000, 32'h0, 32'h0, 0, 0);
    for (int i = 3; i < 7; i++)
      tbl[i] = mk(1, 32'h3E00_0000, 32'h3E00_0000, 1, 32'h4000_0000, 32'h4000_0000,
                  32'h4000_0000, 32'h4200_0000, 0, 0);
    tbl[7]  = mk(1, 32'h3E00_0000, 32'h0, 0, 32'h0, 32'h0, 32'h3E00_0000, 32'h0, 5, 0);
    tbl[8]  = mk(1, 32'h4000_0000, 32'h3E00_0000, 0, 32'h0, 32'h0, 32'h4100_0000, 32'h0, 0, 1);
    tbl[9]  = mk(1, 32'h4000_0000, 32'hBE00_0000, 0, 32'h0, 32'h0, 32'h3E00_0000, 32'h0, 0, 0);
    tbl[10] = mk(0, 32'h0, 32'h0, 1, 32'h3E00_0000, 32'h3E00_0000, 32'h0, 32'h4000_0000, 2, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    for (int k = 0; k < 6; k++) begin
      rv.v0 = 1'($urandom_range(0, 1));
      rv.v1 = rv.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.a0 = rand_fp(); rv.b0 = rand_fp();
      rv.a1 = rand_fp(); rv.b1 = rand_fp();
      rv.r0 = fp_add(rv.a0, rv.b0);
      rv.r1 = fp_add(rv.a1, rv.b1);
      rv.bp = $urandom_range(0, 3);
      rv.ghost = 1'b0;
      run_vec(rv);
    end

    // Abort an operation with reset in its third WAIT cycle.
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h4000_0000;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (bus.req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("abort_grant_timeout");
    @(posedge clock); #1;
    bus.req0_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    chk_reset_vals();
    rr_ptr = 1'b1;
    exp_q.delete();
    seen0 = rsp_seen;
    repeat (2) @(posedge clock);
    #1;
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("no_rsp_after_abort", 37'(rsp_seen - seen0), 37'(0));

    run_vec(tbl[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    fail_now("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The module SHALL have parameter FPU_LATENCY, default 6, the number of cycles after the FPU restart pulse until fpu_data_in/fpu_status_in are valid (legal range 1..15).
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, with ports exactly as listed below (clock and reset first).
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester has an operand pair pending.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32 each  operands in FPU format {sign[31], exp[30:25] bias 31, mant[24:0]}.
REQ-007 req0_ready / req1_ready  output  1 each  grant strobe; the operands are accepted in that cycle.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_data  output  32  result; rsp_status  output  4  FPU status.
REQ-012 fpu_reset  output  1  active-low restart of the shared FPU; fpu_op_a, fpu_op_b  output  32  FPU operands.
REQ-013 fpu_data_in  input  32 and fpu_status_in  input  4  FPU outputs.

Function
REQ-014 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, RESP.
REQ-015 In IDLE with at least one reqN_valid, exactly one reqN_ready SHALL be high combinationally, and the operands and ID SHALL be latched at that edge; next state is LAUNCH.
REQ-016 In LAUNCH (one cycle), fpu_reset SHALL be 0; in every other state it SHALL be 1.
REQ-017 fpu_op_a/fpu_op_b SHALL hold the latched operands from LAUNCH until the next grant, independent of requester inputs.
REQ-018 WAIT SHALL last exactly FPU_LATENCY cycles, counted by a 4-bit down-counter; fpu_data_in/fpu_status_in SHALL be captured on the last WAIT edge; next state is RESP.
REQ-019 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_status/rsp_id SHALL be stable until rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-020 Latency SHALL be exactly FPU_LATENCY+2 cycles from the grant edge to the first rsp_valid cycle; minimum issue interval is FPU_LATENCY+3 cycles.
REQ-021 reqN_ready SHALL be 0 in every state except IDLE; requests that arrive while busy SHALL wait and not be dropped.
REQ-022 A requester that deasserts valid before it is granted SHALL simply not be served; no other state change.
REQ-023 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-024 While reset=0: state IDLE, reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_status=0, fpu_op_a=fpu_op_b=0, fpu_reset=1, counter=0, last-grant pointer=1 (so requester 0 wins the first tie).
REQ-025 Reset asserted mid-operation SHALL abort immediately; the in-flight result SHALL be lost and no rsp_valid SHALL follow.

Configuration
REQ-026 With macro FPU_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last wins, and the pointer updates on each grant.
REQ-027 Without FPU_ARB_RR_EN, requester 0 SHALL always win ties (fixed priority), and no pointer register SHALL be generated.

Structure
REQ-028 A shared package fpu_pkg SHALL hold the FPU field widths (EXP_W=6, MANT_W=25, BIAS=31) and the state enum typedef fpu_arb_state_t.
REQ-029 The grant logic SHALL be a sub-module fpu_arb_grant (inputs: valids, pointer; output: one-hot grant), instantiated once.

Verification
REQ-030 Single request: req0 issues 0x3E000000 + 0x3E000000 (1.0+1.0) -> one LAUNCH pulse, rsp_valid at grant+8 (FPU_LATENCY=6), rsp_data=0x40000000, rsp_id=0.
REQ-031 Simultaneous requests: req0 2.0+2.0 (0x40000000 each), req1 1.0+(-1.0) (0x3E000000, 0xBE000000) -> req0 is served first with 0x42000000; req1 is served next with zero result; two fpu_reset pulses.
REQ-032 Round-robin (FPU_ARB_RR_EN): both valid for four transactions -> grants alternate 0,1,0,1; without the macro -> 0,0,0,0 while req0 stays valid.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable, no new grant, no fpu_reset pulse until accepted.
REQ-034 Reset in WAIT: reset=0 on the third WAIT cycle -> all outputs return to reset values at once; no rsp_valid after release.
REQ-035 Operand isolation: change req0_a during WAIT -> fpu_op_a unchanged, and the result reflects the latched operands (1.0+0.0 -> 0x3E000000).
